shape_record_writer: RTL and testbench
======================================

// Module: shape_record_writer
// PURPOSE
//  Writer end of the shape-record text format: accepts binary shape records
//  (type, width, height) and serialises each one as an ASCII line
//  "<type> <w> <h>\n", e.g. "rectangle 3 4\n", onto a byte stream.
//  It sits between the shape source and a byte sink (file or UART model).
//  Per-type counters of completed lines mirror the per-class shape report.
// PARAMETERS
//  DATA_W   16  width of unsigned integer width/height fields
//  DIG_N    5   max decimal digits, ceil(DATA_W*log10(2)); 5 for 16
//  CNT_W    16  width of per-type line counters
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  rec_valid  in   1       input record valid
//  rec_ready  out  1       writer can accept a record (high only in IDLE)
//  rec_type   in   2       shape_t: 0 rectangle, 1 square, 2 triangle, 3 invalid
//  rec_w      in   DATA_W  width, unsigned
//  rec_h      in   DATA_W  height, unsigned
//  tx_valid   out  1       output byte valid
//  tx_ready   in   1       sink accepts byte
//  tx_data    out  8       ASCII byte
//  busy       out  1       record in progress (state != IDLE)
//  err        out  1       one-cycle pulse: invalid type dropped
//  cnt_rect   out  CNT_W   completed rectangle lines, saturating
//  cnt_sqr    out  CNT_W   completed square lines, saturating
//  cnt_tri    out  CNT_W   completed triangle lines, saturating
// BEHAVIOUR
//  Reset: state IDLE; rec_ready=1, tx_valid=0, tx_data=0, busy=0, err=0, counters=0.
//  Reset mid-record aborts immediately; no partial line is resumed.
//  Accept: rec_valid&&rec_ready latches type/w/h; inputs are ignored after that.
//  Type 3: err=1 next cycle, back to IDLE, no bytes, no counter change.
//  FSM: IDLE -> CONV -> NAME -> SP1 -> WDIG -> SP2 -> HDIG -> NL -> IDLE.
//   CONV: two bin2bcd instances convert w and h in parallel, exactly DATA_W
//    cycles. tx_valid first rises DATA_W+1 cycles after the accept edge.
//   NAME: "rectangle" / "square" / "triangle", lowercase, no terminator.
//   SP1/SP2: 0x20. NL: 0x0A.
//   WDIG/HDIG: decimal, MSD first, leading zeros suppressed; value 0 -> "0".
//  Output handshake: a byte moves on tx_valid&&tx_ready. tx_data and tx_valid
//   stay stable while tx_ready=0. tx_valid is never dropped before the
//   handshake. In emit states tx_valid=1 with no bubbles when tx_ready is
//   held high: 1 byte/cycle.
//  Counter for the latched type increments in the cycle NL is handshaken.
//   At 2^CNT_W-1 it holds.
//  rec_ready returns to 1 the cycle after the NL handshake. Next accept is
//   allowed that cycle. No record overlap.
//  Line length: 9/6/8 name bytes + 3 + digits(w) + digits(h).
// STRUCTURE
//  shape_pkg (shared): typedef enum logic[1:0] shape_t {RECTANGLE, SQUARE,
//   TRIANGLE, SHAPE_INVALID}; ASCII constants ASCII_SP, ASCII_NL,
//   ASCII_ZERO; function shape_name_char(shape_t, idx) -> byte;
//   function shape_name_len(shape_t) -> int.
//  Sub-module shape_bin2bcd: sequential double-dabble, start/done handshake,
//   DATA_W cycles, DIG_N BCD digits out. Instantiated twice (w, h).
//  Top: FSM, byte/digit index counters, leading-zero skip, tx register,
//   counters.
// TESTING
//  1. rectangle w=3 h=4, tx_ready=1 -> bytes "rectangle 3 4\n" (14 bytes);
//     first tx_valid 17 cycles after accept; cnt_rect=1.
//  2. square w=0 h=65535 -> "square 0 65535\n"; cnt_sqr=1; no leading zeros.
//  3. triangle w=100 h=7, tx_ready toggled 1/0 every cycle -> same bytes,
//     "triangle 100 7\n"; tx_data stable while stalled; no drop or duplicate.
//  4. rec_type=3 w=5 h=5 -> err pulse 1 cycle; zero bytes; counters unchanged;
//     rec_ready=1 on the following cycle.
//  5. rst_n low after 4 bytes of "rectangle 12 34\n" -> tx_valid=0 at once;
//     after release the new record "square 1 1\n" is emitted intact.
//  6. back-to-back: 3 records, rec_valid held high -> each accepted the cycle
//     after the previous NL; counters read 1/1/1.

Source files
------------

// File: rtl/shape_pkg.sv
// Shared types, ASCII constants and shape-name helpers for the shape-record writer.
package shape_pkg;

    typedef enum logic [1:0] {
        RECTANGLE     = 2'd0,
        SQUARE        = 2'd1,
        TRIANGLE      = 2'd2,
        SHAPE_INVALID = 2'd3
    } shape_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CONV = 3'd1,
        ST_NAME = 3'd2,
        ST_SP1  = 3'd3,
        ST_WDIG = 3'd4,
        ST_SP2  = 3'd5,
        ST_HDIG = 3'd6,
        ST_NL   = 3'd7
    } wr_state_t;

    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_NL   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam int         NAME_MAX   = 9;

    // Number of characters in the lowercase name of a shape (0 for invalid).
    function automatic int shape_name_len(input shape_t s);
        case (s)
            RECTANGLE: return 9;
            SQUARE:    return 6;
            TRIANGLE:  return 8;
            default:   return 0;
        endcase
    endfunction

    // Character idx (0 = first) of the shape name; 0x00 past the end.
    function automatic logic [7:0] shape_name_char(input shape_t s, input logic [3:0] idx);
        logic [8*NAME_MAX-1:0] name;
        logic [8*NAME_MAX-1:0] sh;
        int                    len;
        case (s)
            RECTANGLE: name = "rectangle";
            SQUARE:    name = {24'h000000, "square"};
            TRIANGLE:  name = {8'h00, "triangle"};
            default:   name = '0;
        endcase
        len = shape_name_len(s);
        if (int'(idx) < len) begin
            sh = name >> (8 * (len - 1 - int'(idx)));
            return sh[7:0];
        end else begin
            return 8'h00;
        end
    endfunction

endpackage

// File: rtl/shape_bin2bcd.sv
// Sequential double-dabble converter: loads on start, runs exactly DATA_W
// shift steps, pulses done on the last step and then holds the BCD result.
module shape_bin2bcd #(
    parameter int DATA_W = 16,
    parameter int DIG_N  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_W-1:0]    bin,
    output logic                 done,
    output logic [4*DIG_N-1:0]   bcd
);
    import shape_pkg::*;

    localparam int BCD_W = 4 * DIG_N;
    localparam int CW    = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;

    // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = b;
        for (int i = 0; i < DIG_N; i++) begin
            d = b[4*i +: 4];
            if (d >= 4'd5) begin
                r[4*i +: 4] = d + 4'd3;
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    // Next-state: load on start, otherwise one adjust-and-shift step per cycle.
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (start) begin
            shift_d = bin;
            bcd_d   = '0;
            cnt_d   = CW'(DATA_W);
        end else if (cnt_q != '0) begin
            {bcd_d, shift_d} = {dabble_adj(bcd_q), shift_q} << 5'd1;
            cnt_d            = cnt_q - CW'(1);
            done_d           = (cnt_q == CW'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/shape_record_writer.sv
// Serialises binary shape records as ASCII lines "<type> <w> <h>\n" onto a
// valid/ready byte stream and keeps saturating per-type line counters.
module shape_record_writer #(
    parameter int DATA_W = 16,
    parameter int DIG_N  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic [1:0]        rec_type,
    input  logic [DATA_W-1:0] rec_w,
    input  logic [DATA_W-1:0] rec_h,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  cnt_rect,
    output logic [CNT_W-1:0]  cnt_sqr,
    output logic [CNT_W-1:0]  cnt_tri
);
    import shape_pkg::*;

    localparam int BCD_W = 4 * DIG_N;

    wr_state_t        state_q, state_d;
    shape_t           type_q, type_d;
    logic [3:0]       idx_q, idx_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             rec_ready_q, rec_ready_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_rect_q, cnt_rect_d;
    logic [CNT_W-1:0] cnt_sqr_q, cnt_sqr_d;
    logic [CNT_W-1:0] cnt_tri_q, cnt_tri_d;

    logic             conv_start_s;
    logic             w_done_s, h_done_s;
    logic [BCD_W-1:0] w_bcd_s, h_bcd_s;
    logic [3:0]       w_msd_s, h_msd_s;
    logic [3:0]       name_last_s;
    logic             tx_fire_s;

    // Decimal digit i (0 = least significant) of a packed BCD value.
    function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] b, input logic [3:0] i);
        logic [BCD_W-1:0] sh;
        sh = b >> (4 * int'(i));
        return sh[3:0];
    endfunction

    // Index of the most significant non-zero digit; 0 when the value is 0,
    // so a zero value still prints a single "0".
    function automatic logic [3:0] bcd_msd(input logic [BCD_W-1:0] b);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < DIG_N; i++) begin
            if (b[4*i +: 4] != 4'd0) begin
                r = 4'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    shape_bin2bcd #(.DATA_W(DATA_W), .DIG_N(DIG_N)) u_w_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start_s),
        .bin   (rec_w),
        .done  (w_done_s),
        .bcd   (w_bcd_s)
    );

    shape_bin2bcd #(.DATA_W(DATA_W), .DIG_N(DIG_N)) u_h_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start_s),
        .bin   (rec_h),
        .done  (h_done_s),
        .bcd   (h_bcd_s)
    );

    assign w_msd_s     = bcd_msd(w_bcd_s);
    assign h_msd_s     = bcd_msd(h_bcd_s);
    assign name_last_s = 4'(shape_name_len(type_q) - 1);
    assign tx_fire_s   = tx_valid_q && tx_ready;

    // Writer FSM: next state, next output byte and counter updates.
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        idx_d        = idx_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        err_d        = 1'b0;
        cnt_rect_d   = cnt_rect_q;
        cnt_sqr_d    = cnt_sqr_q;
        cnt_tri_d    = cnt_tri_q;
        conv_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rec_valid && rec_ready_q) begin
                    if (rec_type == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        type_d       = shape_t'(rec_type);
                        conv_start_s = 1'b1;
                        state_d      = ST_CONV;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (w_done_s && h_done_s) begin
                    state_d    = ST_NAME;
                    idx_d      = 4'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = shape_name_char(type_q, 4'd0);
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_NAME: begin
                if (tx_fire_s) begin
                    if (idx_q == name_last_s) begin
                        state_d   = ST_SP1;
                        tx_data_d = ASCII_SP;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = shape_name_char(type_q, idx_q + 4'd1);
                    end
                end else begin
                    state_d = ST_NAME;
                end
            end
            ST_SP1: begin
                if (tx_fire_s) begin
                    state_d   = ST_WDIG;
                    idx_d     = w_msd_s;
                    tx_data_d = ASCII_ZERO + {4'd0, bcd_digit(w_bcd_s, w_msd_s)};
                end else begin
                    state_d = ST_SP1;
                end
            end
            ST_WDIG: begin
                if (tx_fire_s) begin
                    if (idx_q == 4'd0) begin
                        state_d   = ST_SP2;
                        tx_data_d = ASCII_SP;
                    end else begin
                        idx_d     = idx_q - 4'd1;
                        tx_data_d = ASCII_ZERO + {4'd0, bcd_digit(w_bcd_s, idx_q - 4'd1)};
                    end
                end else begin
                    state_d = ST_WDIG;
                end
            end
            ST_SP2: begin
                if (tx_fire_s) begin
                    state_d   = ST_HDIG;
                    idx_d     = h_msd_s;
                    tx_data_d = ASCII_ZERO + {4'd0, bcd_digit(h_bcd_s, h_msd_s)};
                end else begin
                    state_d = ST_SP2;
                end
            end
            ST_HDIG: begin
                if (tx_fire_s) begin
                    if (idx_q == 4'd0) begin
                        state_d   = ST_NL;
                        tx_data_d = ASCII_NL;
                    end else begin
                        idx_d     = idx_q - 4'd1;
                        tx_data_d = ASCII_ZERO + {4'd0, bcd_digit(h_bcd_s, idx_q - 4'd1)};
                    end
                end else begin
                    state_d = ST_HDIG;
                end
            end
            ST_NL: begin
                if (tx_fire_s) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    case (type_q)
                        RECTANGLE: if (cnt_rect_q != {CNT_W{1'b1}}) cnt_rect_d = cnt_rect_q + CNT_W'(1);
                                   else cnt_rect_d = cnt_rect_q;
                        SQUARE:    if (cnt_sqr_q != {CNT_W{1'b1}}) cnt_sqr_d = cnt_sqr_q + CNT_W'(1);
                                   else cnt_sqr_d = cnt_sqr_q;
                        TRIANGLE:  if (cnt_tri_q != {CNT_W{1'b1}}) cnt_tri_d = cnt_tri_q + CNT_W'(1);
                                   else cnt_tri_d = cnt_tri_q;
                        default:   cnt_rect_d = cnt_rect_q;
                    endcase
                end else begin
                    state_d = ST_NL;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
        rec_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Writer registers; reset aborts any line in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            type_q      <= RECTANGLE;
            idx_q       <= 4'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            rec_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_rect_q  <= '0;
            cnt_sqr_q   <= '0;
            cnt_tri_q   <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            idx_q       <= idx_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            rec_ready_q <= rec_ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            cnt_rect_q  <= cnt_rect_d;
            cnt_sqr_q   <= cnt_sqr_d;
            cnt_tri_q   <= cnt_tri_d;
        end
    end

    assign rec_ready = rec_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign cnt_rect  = cnt_rect_q;
    assign cnt_sqr   = cnt_sqr_q;
    assign cnt_tri   = cnt_tri_q;

endmodule

// File: tb/tb_shape_record_writer.sv
// Directed bench for shape_record_writer: byte streams, latency, stalls,
// invalid type, mid-record reset and back-to-back records.
module tb_shape_record_writer;

    logic        clk;
    logic        rst_n;
    logic        rec_valid;
    logic        rec_ready;
    logic [1:0]  rec_type;
    logic [15:0] rec_w;
    logic [15:0] rec_h;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        busy;
    logic        err;
    logic [15:0] cnt_rect;
    logic [15:0] cnt_sqr;
    logic [15:0] cnt_tri;

    int n_assert = 0;
    int n_fail   = 0;

    shape_record_writer #(.DATA_W(16), .DIG_N(5), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_type  (rec_type),
        .rec_w     (rec_w),
        .rec_h     (rec_h),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .busy      (busy),
        .err       (err),
        .cnt_rect  (cnt_rect),
        .cnt_sqr   (cnt_sqr),
        .cnt_tri   (cnt_tri)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts at the negedge right after the accept edge. Collects bytes on
    // handshakes (tx_ready always 1 in mode 0, toggling in mode 1), checks
    // each against exp, and returns at the negedge where the last wanted
    // byte is about to be handshaken. max_bytes=0 means the whole line.
    task automatic collect(input string tag, input string exp, input int mode,
                           input int exp_lat, input int max_bytes);
        int         cyc;
        int         nb;
        int         first;
        int         limit;
        bit         stall;
        logic [7:0] held;
        cyc   = 0;
        nb    = 0;
        first = -1;
        stall = 1'b0;
        held  = 8'h00;
        limit = (max_bytes > 0) ? max_bytes : exp.len();
        while (nb < limit && cyc < 400) begin
            @(negedge clk);
            cyc++;
            tx_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            if (tx_valid && first < 0) first = cyc;
            if (stall) begin
                check({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
                check({tag, "_stall_data"}, 32'(tx_data), 32'(held));
                stall = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                check($sformatf("%s_byte%0d", tag, nb), 32'(tx_data), 32'(exp[nb]));
                nb++;
            end else if (tx_valid) begin
                stall = 1'b1;
                held  = tx_data;
            end
        end
        check({tag, "_nbytes"}, 32'(nb), 32'(limit));
        if (exp_lat > 0) check({tag, "_latency"}, 32'(first), 32'(exp_lat));
    endtask

    initial begin
        int vcount;
        rst_n     = 1'b1;
        rec_valid = 1'b0;
        rec_type  = 2'd0;
        rec_w     = 16'd0;
        rec_h     = 16'd0;
        tx_ready  = 1'b1;
        #3 rst_n  = 1'b0;
        #1;
        check("rst_ready", 32'(rec_ready), 32'd1);
        check("rst_txv",   32'(tx_valid),  32'd0);
        check("rst_txd",   32'(tx_data),   32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_cnt",   32'({cnt_rect, cnt_sqr} | 32'(cnt_tri)), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: rectangle 3 4, latency check
        @(negedge clk);
        rec_valid = 1'b1; rec_type = 2'd0; rec_w = 16'd3; rec_h = 16'd4;
        check("t1_ready", 32'(rec_ready), 32'd1);
        @(negedge clk);
        rec_valid = 1'b0; rec_w = 16'hFFFF; rec_h = 16'hFFFF; rec_type = 2'd2;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_txv0", 32'(tx_valid), 32'd0);
        collect("t1", "rectangle 3 4\n", 0, 17, 0);
        @(negedge clk);
        check("t1_ready_after", 32'(rec_ready), 32'd1);
        check("t1_busy_after",  32'(busy), 32'd0);
        check("t1_txv_after",   32'(tx_valid), 32'd0);
        check("t1_cnt_rect",    32'(cnt_rect), 32'd1);

        // 2: square 0 65535
        rec_valid = 1'b1; rec_type = 2'd1; rec_w = 16'd0; rec_h = 16'd65535;
        @(negedge clk);
        rec_valid = 1'b0;
        collect("t2", "square 0 65535\n", 0, 17, 0);
        @(negedge clk);
        check("t2_cnt_sqr", 32'(cnt_sqr), 32'd1);

        // 3: triangle 100 7 with tx_ready toggling
        rec_valid = 1'b1; rec_type = 2'd2; rec_w = 16'd100; rec_h = 16'd7;
        @(negedge clk);
        rec_valid = 1'b0;
        collect("t3", "triangle 100 7\n", 1, 0, 0);
        tx_ready = 1'b1;
        @(negedge clk);
        check("t3_cnt_tri", 32'(cnt_tri), 32'd1);

        // 4: invalid type
        rec_valid = 1'b1; rec_type = 2'd3; rec_w = 16'd5; rec_h = 16'd5;
        @(negedge clk);
        rec_valid = 1'b0;
        check("t4_err",   32'(err), 32'd1);
        check("t4_ready", 32'(rec_ready), 32'd1);
        check("t4_busy",  32'(busy), 32'd0);
        @(negedge clk);
        check("t4_err_pulse", 32'(err), 32'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) vcount++;
            @(negedge clk);
        end
        check("t4_nobytes", 32'(vcount), 32'd0);
        check("t4_cnts", 32'({cnt_rect[7:0], cnt_sqr[7:0], cnt_tri[7:0]}), 32'h010101);

        // 5: reset after 4 bytes, then a fresh record
        rec_valid = 1'b1; rec_type = 2'd0; rec_w = 16'd12; rec_h = 16'd34;
        @(negedge clk);
        rec_valid = 1'b0;
        collect("t5a", "rectangle 12 34\n", 0, 0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_txv_rst",  32'(tx_valid), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_cnt_rst",  32'(cnt_rect), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_idle_txv", 32'(tx_valid), 32'd0);
        rec_valid = 1'b1; rec_type = 2'd1; rec_w = 16'd1; rec_h = 16'd1;
        @(negedge clk);
        rec_valid = 1'b0;
        collect("t5b", "square 1 1\n", 0, 17, 0);
        @(negedge clk);
        check("t5_cnt_sqr",  32'(cnt_sqr), 32'd1);
        check("t5_cnt_rect", 32'(cnt_rect), 32'd0);

        // 6: back-to-back with rec_valid held high
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rec_valid = 1'b1; rec_type = 2'd0; rec_w = 16'd5; rec_h = 16'd6;
        check("t6_ready_a", 32'(rec_ready), 32'd1);
        @(negedge clk);
        rec_type = 2'd1; rec_w = 16'd7; rec_h = 16'd8;
        check("t6_busy_a", 32'(busy), 32'd1);
        check("t6_notready_a", 32'(rec_ready), 32'd0);
        collect("t6a", "rectangle 5 6\n", 0, 17, 0);
        @(negedge clk);
        check("t6_ready_b", 32'(rec_ready), 32'd1);
        @(negedge clk);
        rec_type = 2'd2; rec_w = 16'd9; rec_h = 16'd10;
        check("t6_busy_b", 32'(busy), 32'd1);
        check("t6_cnt_rect", 32'(cnt_rect), 32'd1);
        collect("t6b", "square 7 8\n", 0, 17, 0);
        @(negedge clk);
        check("t6_ready_c", 32'(rec_ready), 32'd1);
        @(negedge clk);
        rec_valid = 1'b0;
        check("t6_busy_c", 32'(busy), 32'd1);
        collect("t6c", "triangle 9 10\n", 0, 17, 0);
        @(negedge clk);
        check("t6_cnt_rect_f", 32'(cnt_rect), 32'd1);
        check("t6_cnt_sqr_f",  32'(cnt_sqr), 32'd1);
        check("t6_cnt_tri_f",  32'(cnt_tri), 32'd1);
        check("t6_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
